// File: rtl/m2_pingpong_block_buffer.sv
// Ping-pong NxN block store: writer fills one bank row-major while reader drains the other row- or column-major.
// First read word 2 cycles after the write-done pulse; both sides valid/ready, and the output holds while stalled.
module m2_pingpong_block_buffer #(
    parameter int DATA_W  = 32,
    parameter int BLK_DIM = 8
) (
    input  logic              CLOCK_I,
    input  logic              RESETN_I,
    input  logic              WR_VALID_I,
    input  logic [DATA_W-1:0] WR_DATA_I,
    output logic              WR_READY_O,
    output logic              WR_BLOCK_DONE_O,
    input  logic              RD_TRANSPOSE_I,
    output logic              RD_VALID_O,
    output logic [DATA_W-1:0] RD_DATA_O,
    output logic              RD_LAST_O,
    input  logic              RD_READY_I,
    output logic              RD_BLOCK_DONE_O,
    output logic [1:0]        BANK_FULL_O
);
    localparam int WORDS  = BLK_DIM * BLK_DIM;
    localparam int ADDR_W = $clog2(WORDS);
    localparam int LOG_N  = $clog2(BLK_DIM);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} rd_state_t;

    logic [DATA_W-1:0] mem [2*WORDS];
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_bank;
    logic              rd_bank;
    logic              tr_q;
    logic [1:0]        full;
    logic              wr_fire;
    logic              wr_fill;
    logic              rd_free;
    logic              issue;
    logic              pop;
    logic [DATA_W-1:0] fifo_dat [2];
    logic [1:0]        fifo_last;
    logic              wptr;
    logic              rptr;
    logic [1:0]        fifo_cnt;
    rd_state_t         state;
    rd_state_t         state_nxt;

    assign wr_fire = WR_VALID_I & ~full[wr_bank];
    assign wr_fill = wr_fire & (wr_cnt == LAST_ADDR);
    assign pop     = (fifo_cnt != 2'd0) & RD_READY_I;
    // Low counter bits are the inner loop; swapping the halves walks columns instead of rows.
    assign rd_addr = tr_q ? {rd_cnt[LOG_N-1:0], rd_cnt[ADDR_W-1:LOG_N]} : rd_cnt;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        rd_free   = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) state_nxt = RD_ISSUE;
            end
            RD_ISSUE: begin
                // A pop this cycle frees the slot the new word lands in.
                if ((fifo_cnt != 2'd2) || pop) begin
                    issue = 1'b1;
                    if (rd_cnt == LAST_ADDR) state_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (pop && fifo_last[rptr]) begin
                    rd_free   = 1'b1;
                    state_nxt = RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_I) begin
        if (wr_fire) mem[{wr_bank, wr_cnt}] <= WR_DATA_I;
    end

    always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            wr_cnt          <= '0;
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            rd_cnt          <= '0;
            tr_q            <= 1'b0;
            full            <= 2'b00;
            state           <= RD_IDLE;
            WR_BLOCK_DONE_O <= 1'b0;
            RD_BLOCK_DONE_O <= 1'b0;
            fifo_dat[0]     <= '0;
            fifo_dat[1]     <= '0;
            fifo_last       <= 2'b00;
            wptr            <= 1'b0;
            rptr            <= 1'b0;
            fifo_cnt        <= 2'd0;
        end else begin
            state           <= state_nxt;
            WR_BLOCK_DONE_O <= wr_fill;
            RD_BLOCK_DONE_O <= rd_free;
            if (wr_fire) wr_cnt <= wr_fill ? '0 : wr_cnt + 1'b1;
            if (wr_fill) begin
                wr_bank       <= ~wr_bank;
                full[wr_bank] <= 1'b1;
            end
            if (rd_free) begin
                rd_bank       <= ~rd_bank;
                full[rd_bank] <= 1'b0;
            end
            if (state == RD_IDLE && full[rd_bank]) begin
                tr_q   <= RD_TRANSPOSE_I;
                rd_cnt <= '0;
            end
            if (issue) begin
                rd_cnt          <= rd_cnt + 1'b1;
                fifo_dat[wptr]  <= mem[{rd_bank, rd_addr}];
                fifo_last[wptr] <= (rd_cnt == LAST_ADDR);
                wptr            <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            fifo_cnt <= fifo_cnt + {1'b0, issue} - {1'b0, pop};
        end
    end

    assign WR_READY_O  = ~full[wr_bank];
    assign RD_VALID_O  = (fifo_cnt != 2'd0);
    assign RD_DATA_O   = fifo_dat[rptr];
    assign RD_LAST_O   = fifo_last[rptr];
    assign BANK_FULL_O = full;

endmodule

// File: tb/tb_m2_pingpong_block_buffer.sv
// Directed bench for the ping-pong block buffer: scoreboarded reads, handshake counters, reset checks.
module tb_m2_pingpong_block_buffer;
    localparam int DW = 32;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic          CLOCK_I = 1'b0;
    logic          RESETN_I;
    logic          WR_VALID_I;
    logic [DW-1:0] WR_DATA_I;
    logic          WR_READY_O;
    logic          WR_BLOCK_DONE_O;
    logic          RD_TRANSPOSE_I;
    logic          RD_VALID_O;
    logic [DW-1:0] RD_DATA_O;
    logic          RD_LAST_O;
    logic          RD_READY_I;
    logic          RD_BLOCK_DONE_O;
    logic [1:0]    BANK_FULL_O;

    m2_pingpong_block_buffer #(.DATA_W(DW), .BLK_DIM(N)) dut (
        .CLOCK_I(CLOCK_I), .RESETN_I(RESETN_I),
        .WR_VALID_I(WR_VALID_I), .WR_DATA_I(WR_DATA_I), .WR_READY_O(WR_READY_O),
        .WR_BLOCK_DONE_O(WR_BLOCK_DONE_O), .RD_TRANSPOSE_I(RD_TRANSPOSE_I),
        .RD_VALID_O(RD_VALID_O), .RD_DATA_O(RD_DATA_O), .RD_LAST_O(RD_LAST_O),
        .RD_READY_I(RD_READY_I), .RD_BLOCK_DONE_O(RD_BLOCK_DONE_O), .BANK_FULL_O(BANK_FULL_O)
    );

    always #5 CLOCK_I = ~CLOCK_I;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DW-1:0] wr_q [$];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   got_q [$];
    int   rd_mode;
    bit   wr_rand;
    int   writes, wr_done_cnt, rd_done_cnt, stable_err;
    int   wr_done_cyc, first_valid_cyc, first_rd_cyc, last_rd_cyc;
    logic [1:0] full_at_done;
    bit   hold_pending, prev_valid;
    logic [DW-1:0] held_dat;
    logic held_last;

    task automatic clear_stats();
        writes = 0; wr_done_cnt = 0; rd_done_cnt = 0; stable_err = 0;
        wr_done_cyc = -1; first_valid_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
        full_at_done = 2'b00; hold_pending = 0; prev_valid = 0;
        got_q.delete(); exp_q.delete(); wr_q.delete();
    endtask

    // Expected read order: word k of the block comes from address r*N+c.
    task automatic queue_block(input logic [DW-1:0] base, input bit tr, input bit rnd);
        logic [DW-1:0] blk [NN];
        int addr;
        logic lst;
        for (int k = 0; k < NN; k++) begin
            blk[k] = rnd ? DW'($urandom) : base + DW'(k);
            wr_q.push_back(blk[k]);
        end
        for (int k = 0; k < NN; k++) begin
            addr = tr ? ((k % N) * N + k / N) : k;
            lst  = (k == NN - 1);
            exp_q.push_back({lst, blk[addr]});
        end
    endtask

    task automatic cycle();
        @(negedge CLOCK_I);
        cyc++;
        if (WR_BLOCK_DONE_O) begin
            wr_done_cnt++;
            if (wr_done_cyc < 0) begin
                wr_done_cyc  = cyc;
                full_at_done = BANK_FULL_O;
            end
        end
        if (RD_BLOCK_DONE_O) rd_done_cnt++;
        if (RD_VALID_O && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        prev_valid = RD_VALID_O;
        if (hold_pending && (!RD_VALID_O || RD_DATA_O !== held_dat || RD_LAST_O !== held_last))
            stable_err++;
        WR_VALID_I = (wr_q.size() > 0) && (!wr_rand || ($urandom_range(0, 1) == 1));
        WR_DATA_I  = (wr_q.size() > 0) ? wr_q[0] : '0;
        RD_READY_I = (rd_mode == 2) ? ($urandom_range(0, 1) == 1) : (rd_mode == 1);
        if (WR_VALID_I && WR_READY_O) begin
            void'(wr_q.pop_front());
            writes++;
        end
        if (RD_VALID_O && RD_READY_I) begin
            got_q.push_back({RD_LAST_O, RD_DATA_O});
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
        end
        hold_pending = RD_VALID_O && !RD_READY_I;
        held_dat     = RD_DATA_O;
        held_last    = RD_LAST_O;
    endtask

    task automatic run_reads(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) cycle();
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_reset();
        checks++; if (WR_READY_O !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", WR_READY_O); end
        checks++; if (RD_VALID_O !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", RD_VALID_O); end
        checks++; if (RD_DATA_O !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", RD_DATA_O); end
        checks++; if (RD_LAST_O !== 1'b0) begin failures++; $display("FAIL reset_rd_last got=%b exp=0", RD_LAST_O); end
        checks++; if (WR_BLOCK_DONE_O !== 1'b0 || RD_BLOCK_DONE_O !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b%b exp=00", WR_BLOCK_DONE_O, RD_BLOCK_DONE_O); end
        checks++; if (BANK_FULL_O !== 2'b00) begin failures++; $display("FAIL reset_bank_full got=%b exp=00", BANK_FULL_O); end
    endtask

    task automatic test_row_major();
        clear_stats(); rd_mode = 1; wr_rand = 0; RD_TRANSPOSE_I = 1'b0;
        queue_block(32'd0, 1'b0, 1'b0);
        run_reads(NN, 400);
        checks++; if (got_q.size() != NN) begin failures++; $display("FAIL row_count got=%0d exp=%0d", got_q.size(), NN); end
        for (int k = 0; k < NN; k++) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL row_word[%0d] got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]);
            end
        end
        checks++; if (first_valid_cyc - wr_done_cyc != 2) begin
            failures++; $display("FAIL row_latency got=%0d exp=2", first_valid_cyc - wr_done_cyc); end
        checks++; if (last_rd_cyc - first_rd_cyc != NN - 1) begin
            failures++; $display("FAIL row_throughput got=%0d exp=%0d", last_rd_cyc - first_rd_cyc, NN - 1); end
        checks++; if (full_at_done !== 2'b01) begin failures++; $display("FAIL row_full_at_done got=%b exp=01", full_at_done); end
        checks++; if (wr_done_cnt != 1 || rd_done_cnt != 1) begin
            failures++; $display("FAIL row_done_pulses got=%0d/%0d exp=1/1", wr_done_cnt, rd_done_cnt); end
        checks++; if (BANK_FULL_O !== 2'b00) begin failures++; $display("FAIL row_bank_free got=%b exp=00", BANK_FULL_O); end
    endtask

    task automatic test_transpose();
        clear_stats(); rd_mode = 1; wr_rand = 0; RD_TRANSPOSE_I = 1'b1;
        queue_block(32'd0, 1'b1, 1'b0);
        run_reads(NN, 400);
        checks++; if (got_q.size() != NN) begin failures++; $display("FAIL tr_count got=%0d exp=%0d", got_q.size(), NN); end
        for (int k = 0; k < NN; k++) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL tr_word[%0d] got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]);
            end
        end
        checks++; if (full_at_done !== 2'b10) begin failures++; $display("FAIL tr_full_at_done got=%b exp=10", full_at_done); end
        checks++; if (wr_done_cnt != 1 || rd_done_cnt != 1) begin
            failures++; $display("FAIL tr_done_pulses got=%0d/%0d exp=1/1", wr_done_cnt, rd_done_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_stats(); rd_mode = 0; wr_rand = 0; RD_TRANSPOSE_I = 1'b0;
        for (int b = 0; b < 3; b++) queue_block(32'd1000 + 32'(b * 100), 1'b0, 1'b0);
        for (int i = 0; i < 250; i++) cycle();
        checks++; if (writes != 2 * NN) begin failures++; $display("FAIL b2b_stall_writes got=%0d exp=%0d", writes, 2 * NN); end
        checks++; if (WR_READY_O !== 1'b0) begin failures++; $display("FAIL b2b_wr_ready got=%b exp=0", WR_READY_O); end
        checks++; if (BANK_FULL_O !== 2'b11) begin failures++; $display("FAIL b2b_both_full got=%b exp=11", BANK_FULL_O); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL b2b_no_reads got=%0d exp=0", got_q.size()); end
        rd_mode = 1;
        run_reads(3 * NN, 1000);
        checks++; if (got_q.size() != 3 * NN) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 3 * NN); end
        for (int k = 0; k < 3 * NN; k++) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL b2b_word[%0d] got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]);
            end
        end
        checks++; if (writes != 3 * NN) begin failures++; $display("FAIL b2b_writer_resumed got=%0d exp=%0d", writes, 3 * NN); end
        checks++; if (wr_done_cnt != 3 || rd_done_cnt != 3) begin
            failures++; $display("FAIL b2b_done_pulses got=%0d/%0d exp=3/3", wr_done_cnt, rd_done_cnt); end
        checks++; if (stable_err != 0) begin failures++; $display("FAIL b2b_stable got=%0d exp=0", stable_err); end
        checks++; if (BANK_FULL_O !== 2'b00) begin failures++; $display("FAIL b2b_bank_free got=%b exp=00", BANK_FULL_O); end
    endtask

    task automatic test_random();
        clear_stats(); rd_mode = 2; wr_rand = 1; RD_TRANSPOSE_I = 1'b1;
        for (int b = 0; b < 20; b++) queue_block(32'd0, 1'b1, 1'b1);
        run_reads(20 * NN, 20000);
        checks++; if (got_q.size() != 20 * NN) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), 20 * NN); end
        for (int k = 0; k < 20 * NN; k++) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL rnd_word[%0d] got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]);
            end
        end
        checks++; if (stable_err != 0) begin failures++; $display("FAIL rnd_stable got=%0d exp=0", stable_err); end
        checks++; if (wr_done_cnt != 20 || rd_done_cnt != 20) begin
            failures++; $display("FAIL rnd_done_pulses got=%0d/%0d exp=20/20", wr_done_cnt, rd_done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_stats(); rd_mode = 0; wr_rand = 0; RD_TRANSPOSE_I = 1'b0;
        queue_block(32'd5000, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) wr_q.push_back(32'd7000 + 32'(k));
        for (int i = 0; i < 300 && writes < NN + 30; i++) cycle();
        checks++; if (writes != NN + 30) begin failures++; $display("FAIL mid_prefill got=%0d exp=%0d", writes, NN + 30); end
        rd_mode = 1;
        for (int i = 0; i < 10; i++) cycle();
        checks++; if (got_q.size() == 0 || got_q.size() >= NN) begin
            failures++; $display("FAIL mid_partial_read got=%0d exp=1..%0d", got_q.size(), NN - 1); end
        @(negedge CLOCK_I);
        RESETN_I = 1'b0; WR_VALID_I = 1'b0; RD_READY_I = 1'b0;
        #1;
        checks++; if (WR_READY_O !== 1'b1 || RD_VALID_O !== 1'b0 || RD_LAST_O !== 1'b0 || RD_DATA_O !== '0) begin
            failures++; $display("FAIL mid_reset_outputs got=rdy%b vld%b last%b dat%h exp=rdy1 vld0 last0 dat0",
                                 WR_READY_O, RD_VALID_O, RD_LAST_O, RD_DATA_O); end
        checks++; if (BANK_FULL_O !== 2'b00 || WR_BLOCK_DONE_O !== 1'b0 || RD_BLOCK_DONE_O !== 1'b0) begin
            failures++; $display("FAIL mid_reset_flags got=full%b done%b%b exp=full00 done00",
                                 BANK_FULL_O, WR_BLOCK_DONE_O, RD_BLOCK_DONE_O); end
        @(negedge CLOCK_I); @(negedge CLOCK_I);
        RESETN_I = 1'b1;
        @(negedge CLOCK_I);
        checks++; if (WR_BLOCK_DONE_O !== 1'b0 || RD_BLOCK_DONE_O !== 1'b0 || RD_VALID_O !== 1'b0) begin
            failures++; $display("FAIL mid_post_reset got=done%b%b vld%b exp=done00 vld0",
                                 WR_BLOCK_DONE_O, RD_BLOCK_DONE_O, RD_VALID_O); end
        clear_stats(); rd_mode = 1;
        queue_block(32'd6000, 1'b0, 1'b0);
        run_reads(NN, 400);
        checks++; if (got_q.size() != NN) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", got_q.size(), NN); end
        for (int k = 0; k < NN; k++) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL mid_word[%0d] got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]);
            end
        end
        checks++; if (full_at_done !== 2'b01) begin failures++; $display("FAIL mid_bank0 got=%b exp=01", full_at_done); end
        checks++; if (wr_done_cnt != 1 || rd_done_cnt != 1) begin
            failures++; $display("FAIL mid_done_pulses got=%0d/%0d exp=1/1", wr_done_cnt, rd_done_cnt); end
    endtask

    initial begin
        RESETN_I = 1'b0; WR_VALID_I = 1'b0; WR_DATA_I = '0;
        RD_TRANSPOSE_I = 1'b0; RD_READY_I = 1'b0;
        rd_mode = 0; wr_rand = 0;
        clear_stats();
        repeat (3) @(negedge CLOCK_I);
        RESETN_I = 1'b1;
        @(negedge CLOCK_I);
        test_reset();
        test_row_major();
        test_transpose();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
